mem_arbiter_n: RTL and testbench

//  Parametrised N-port cache-line memory arbiter, successor to the fixed 2-port icache/dcache arbiter.

---
 rtl/mem_arb_types.sv | 5 +
 rtl/arb_picker.sv | 27 ++
 rtl/mem_arbiter_n.sv | 91 +++++++++
 tb/tb_mem_arbiter_n.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/mem_arb_types.sv
// mem_arb_types: shared FSM state and operation encodings for the memory arbiter
package mem_arb_types;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} arb_state_t;
  typedef enum logic {ARB_READ = 1'b0, ARB_WRITE = 1'b1} arb_op_t;
endpackage

// File: rtl/arb_picker.sv
// arb_picker: combinational winner selection, fixed priority or round-robin from a pointer
module arb_picker #(
  parameter int NUM_PORTS = 2,
  parameter int RR_MODE   = 0,
  parameter int IW        = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] pending,
  input  logic [IW-1:0]        ptr,
  output logic                 valid,
  output logic [IW-1:0]        winner
);
  logic          found;
  logic [IW-1:0] idx;
  always_comb begin
    valid  = |pending;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = (RR_MODE != 0) ? IW'((int'(ptr) + k) % NUM_PORTS) : IW'(k);
      if (!found && pending[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mem_arbiter_n.sv
// mem_arbiter_n: serialises N cache line requests onto one downstream memory port
module mem_arbiter_n
  import mem_arb_types::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32,
  parameter int RR_MODE    = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_PORTS-1:0]                 req_read,
  input  logic [NUM_PORTS-1:0]                 req_write,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] req_address,
  input  logic [NUM_PORTS-1:0][LINE_WIDTH-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]                 req_resp,
  output logic [LINE_WIDTH-1:0]                req_rdata,
  output logic                                 pmem_read,
  output logic                                 pmem_write,
  output logic [ADDR_WIDTH-1:0]                pmem_address,
  output logic [LINE_WIDTH-1:0]                pmem_wdata,
  input  logic                                 pmem_resp,
  input  logic [LINE_WIDTH-1:0]                pmem_rdata
);
  localparam int IW = $clog2(NUM_PORTS);
  arb_state_t            state_q, state_d;
  arb_op_t               op_q, op_d;
  logic [IW-1:0]         grant_q, grant_d, ptr_q, ptr_d, winner;
  logic                  valid;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [NUM_PORTS-1:0]  pending;
  assign pending = req_read | req_write;
  arb_picker #(.NUM_PORTS(NUM_PORTS), .RR_MODE(RR_MODE), .IW(IW)) u_picker (
    .pending (pending),
    .ptr     (ptr_q),
    .valid   (valid),
    .winner  (winner)
  );
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if (state_q == IDLE) begin
      if (valid) begin
        state_d = BUSY;
        grant_d = winner;
        op_d    = req_write[winner] ? ARB_WRITE : ARB_READ;
        addr_d  = req_address[winner];
        wdata_d = req_wdata[winner];
        ptr_d   = (RR_MODE != 0) ? ((winner == IW'(NUM_PORTS - 1)) ? '0 : winner + 1'b1) : ptr_q;
      end
    end else if (state_q == BUSY) begin
      if (pmem_resp) begin
        state_d = RESP;
        rdata_d = pmem_rdata;
      end
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= ARB_READ;
      grant_q <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
  assign req_resp     = (state_q == RESP) ? (NUM_PORTS'(1) << grant_q) : '0;
  assign req_rdata    = rdata_q;
  assign pmem_read    = (state_q == BUSY) && (op_q == ARB_READ);
  assign pmem_write   = (state_q == BUSY) && (op_q == ARB_WRITE);
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
endmodule

// File: tb/tb_mem_arbiter_n.sv
// tb_mem_arbiter_n: directed checks of a fixed-priority and a round-robin 4-port arbiter
module tb_mem_arbiter_n;
  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       req_read, req_write;
  logic [3:0][31:0] req_address;
  logic [3:0][255:0] req_wdata;
  logic             pmem_resp;
  logic [255:0]     pmem_rdata;
  logic [3:0]       f_resp, r_resp;
  logic [255:0]     f_rdata, r_rdata, f_wdata, r_wdata;
  logic             f_rd, f_wr, r_rd, r_wr;
  logic [31:0]      f_addr, r_addr;
  int               checks = 0;
  int               failures = 0;
  always #5 clk = ~clk;
  mem_arbiter_n #(.NUM_PORTS(4), .RR_MODE(0)) u_fix (
    .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
    .req_address(req_address), .req_wdata(req_wdata), .req_resp(f_resp), .req_rdata(f_rdata),
    .pmem_read(f_rd), .pmem_write(f_wr), .pmem_address(f_addr), .pmem_wdata(f_wdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );
  mem_arbiter_n #(.NUM_PORTS(4), .RR_MODE(1)) u_rr (
    .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
    .req_address(req_address), .req_wdata(req_wdata), .req_resp(r_resp), .req_rdata(r_rdata),
    .pmem_read(r_rd), .pmem_write(r_wr), .pmem_address(r_addr), .pmem_wdata(r_wdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // Runs one transaction from IDLE with requests pending and checks which port each instance acks.
  task automatic txn(input string tag, input logic [3:0] exp_f, input logic [3:0] exp_r);
    tick;
    pmem_resp = 1'b1;
    tick;
    pmem_resp = 1'b0;
    chk({tag, "_fix"}, 256'(f_resp), 256'(exp_f));
    chk({tag, "_rr"}, 256'(r_resp), 256'(exp_r));
    tick;
  endtask
  initial begin
    rst = 1'b1;
    req_read = 4'b0011;
    req_write = '0;
    req_address = '0;
    req_wdata = '0;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    tick;
    tick;
    chk("rst_rd", 256'({f_rd, r_rd, f_wr, r_wr}), 256'(0));
    chk("rst_resp", 256'({f_resp, r_resp}), 256'(0));
    chk("rst_addr", 256'({f_addr, r_addr}), 256'(0));
    chk("rst_rdata", f_rdata | r_rdata, 256'(0));
    chk("rst_wdata", f_wdata | r_wdata, 256'(0));
    rst = 1'b0;
    chk("rst_low_idle", 256'({f_rd, r_rd}), 256'(0));
    tick;
    chk("post_rst_rd", 256'({f_rd, r_rd}), 256'(2'b11));
    pmem_rdata = 256'hBEEF;
    pmem_resp = 1'b1;
    tick;
    pmem_resp = 1'b0;
    req_read = '0;
    chk("first_ack", 256'({f_resp, r_resp}), 256'(8'b0001_0001));
    chk("first_rdata", r_rdata, 256'hBEEF);
    tick;
    chk("first_ack_once", 256'({f_resp, r_resp}), 256'(0));
    req_read = 4'b0010;
    req_address[1] = 32'h0000_1040;
    tick;
    chk("rd_addr_fix", 256'(f_addr), 256'(32'h1040));
    chk("rd_addr_rr", 256'(r_addr), 256'(32'h1040));
    for (int i = 0; i < 4; i++) begin
      chk("rd_hold", 256'({f_rd, r_rd, f_wr, r_wr, f_resp, r_resp}), 256'(12'b1100_0000_0000));
      tick;
    end
    pmem_rdata = {32{8'hA5}};
    pmem_resp = 1'b1;
    tick;
    pmem_resp = 1'b0;
    req_read = '0;
    chk("rd_ack", 256'({f_resp, r_resp}), 256'(8'b0010_0010));
    chk("rd_rdata_fix", f_rdata, {32{8'hA5}});
    chk("rd_rdata_rr", r_rdata, {32{8'hA5}});
    chk("rd_drop", 256'({f_rd, r_rd}), 256'(0));
    tick;
    chk("rd_ack_once", 256'({f_resp, r_resp}), 256'(0));
    req_read = 4'b1001;
    txn("fixed_a", 4'b0001, 4'b1000);
    txn("fixed_b", 4'b0001, 4'b0001);
    txn("fixed_c", 4'b0001, 4'b1000);
    req_read = 4'b1111;
    txn("rr_0", 4'b0001, 4'b0001);
    txn("rr_1", 4'b0001, 4'b0010);
    txn("rr_2", 4'b0001, 4'b0100);
    txn("rr_3", 4'b0001, 4'b1000);
    txn("rr_4", 4'b0001, 4'b0001);
    req_read = '0;
    req_write = 4'b0001;
    req_address[0] = 32'h0000_2000;
    req_wdata[0] = 256'h1234;
    tick;
    chk("wr_op", 256'({f_wr, f_rd, r_wr, r_rd}), 256'(4'b1010));
    chk("wr_addr", 256'(f_addr), 256'(32'h2000));
    chk("wr_wdata", f_wdata, 256'h1234);
    req_write = '0;
    req_address[0] = 32'hFFFF_FFFF;
    req_wdata[0] = '0;
    tick;
    chk("wr_hold_op", 256'({f_wr, r_wr}), 256'(2'b11));
    chk("wr_hold_addr", 256'(r_addr), 256'(32'h2000));
    chk("wr_hold_wdata", r_wdata, 256'h1234);
    pmem_rdata = 256'h77;
    pmem_resp = 1'b1;
    tick;
    pmem_resp = 1'b0;
    chk("wr_ack", 256'({f_resp, r_resp}), 256'(8'b0001_0001));
    chk("wr_drop", 256'({f_wr, r_wr}), 256'(0));
    tick;
    tick;
    chk("wr_idle", 256'({f_rd, f_wr, r_rd, r_wr, f_resp, r_resp}), 256'(0));
    req_read = 4'b0100;
    req_address[2] = 32'h0000_3000;
    tick;
    chk("rb_busy", 256'({f_rd, r_rd}), 256'(2'b11));
    rst = 1'b1;
    tick;
    rst = 1'b0;
    req_read = '0;
    chk("rb_rd", 256'({f_rd, r_rd}), 256'(0));
    chk("rb_resp", 256'({f_resp, r_resp}), 256'(0));
    chk("rb_addr", 256'({f_addr, r_addr}), 256'(0));
    pmem_resp = 1'b1;
    tick;
    pmem_resp = 1'b0;
    chk("rb_stray_resp", 256'({f_resp, r_resp, f_rd, r_rd}), 256'(0));
    tick;
    chk("rb_no_ack", 256'({f_resp, r_resp}), 256'(0));
    req_read = 4'b1010;
    txn("rb_ptr", 4'b0010, 4'b0010);
    req_read = '0;
    tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
